// File: rtl/uart_tx_ctrl_if.sv
// Byte-source / baud-generator / TX-pin bundle for the UART transmit sequencer.
// slave: the controller side. master: the byte source and baud generator side.
interface uart_tx_ctrl_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;
  logic [2:0]           cfg_baud_set;
  logic                 cfg_parity_en;
  logic                 cfg_parity_odd;
  logic                 cfg_two_stop;
  logic                 baud_tick;
  logic                 baud_ena;
  logic [2:0]           baud_set;
  logic                 tx_line;
  logic                 tx_busy;
  logic                 tx_done;
  logic                 tx_err;

  modport master (
    output tx_valid, tx_data, cfg_baud_set, cfg_parity_en, cfg_parity_odd,
           cfg_two_stop, baud_tick,
    input  tx_ready, baud_ena, baud_set, tx_line, tx_busy, tx_done, tx_err
  );

  modport slave (
    input  tx_valid, tx_data, cfg_baud_set, cfg_parity_en, cfg_parity_odd,
           cfg_two_stop, baud_tick,
    output tx_ready, baud_ena, baud_set, tx_line, tx_busy, tx_done, tx_err
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: accepts a byte plus frame config, enables the
// baud generator, aligns to its tick and shifts out start, data (LSB first),
// optional parity and 1 or 2 stop bits. A watchdog aborts the frame if ticks
// stop arriving.
module uart_tx_ctrl #(
  parameter int unsigned DATA_BITS    = 8,
  parameter logic [2:0]  DEFAULT_BAUD = 3'b011,
  parameter int unsigned TICK_TIMEOUT = 200_000
) (
  input logic            clk,
  input logic            reset_n,
  uart_tx_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [19:0] WD_LIMIT = 20'(TICK_TIMEOUT - 1);

  state_t               r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [2:0]           r_bit_cnt;
  logic                 r_stop_cnt;
  logic                 r_par;
  logic                 r_par_en;
  logic                 r_two_stop;
  logic [19:0]          r_wd;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_ena;
  logic [2:0]           r_baud_set;
  logic                 r_line;
  logic                 r_done;
  logic                 r_err;

  logic                 w_accept;
  logic [2:0]           w_baud_code;
  logic                 w_wd_expired;

  // tx_ready is only high in IDLE, so it doubles as the IDLE qualifier.
  assign w_accept     = r_ready & bus.tx_valid;
  // Codes 110/111 are not valid baud rates; fall back to 9600 Bd.
  assign w_baud_code  = (bus.cfg_baud_set[2:1] == 2'b11) ? 3'b011 : bus.cfg_baud_set;
  assign w_wd_expired = (r_wd == WD_LIMIT);

  assign bus.tx_ready = r_ready;
  assign bus.tx_busy  = r_busy;
  assign bus.baud_ena = r_ena;
  assign bus.baud_set = r_baud_set;
  assign bus.tx_line  = r_line;
  assign bus.tx_done  = r_done;
  assign bus.tx_err   = r_err;

  // Frame sequencer with watchdog; every output is a register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_par      <= 1'b0;
      r_par_en   <= 1'b0;
      r_two_stop <= 1'b0;
      r_wd       <= '0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_ena      <= 1'b0;
      r_baud_set <= DEFAULT_BAUD;
      r_line     <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_accept) begin
          r_shift    <= bus.tx_data;
          r_par      <= (^bus.tx_data) ^ bus.cfg_parity_odd;
          r_par_en   <= bus.cfg_parity_en;
          r_two_stop <= bus.cfg_two_stop;
          r_baud_set <= w_baud_code;
          r_wd       <= '0;
          r_ready    <= 1'b0;
          r_busy     <= 1'b1;
          r_ena      <= 1'b1;
          r_state    <= S_ALIGN;
        end
      end else if (bus.baud_tick) begin
        // A tick takes priority over a coincident watchdog expiry.
        r_wd <= '0;
        case (r_state)
          S_ALIGN: begin
            r_line  <= 1'b0;
            r_state <= S_START;
          end
          S_START: begin
            r_line    <= r_shift[0];
            r_bit_cnt <= '0;
            r_state   <= S_DATA;
          end
          S_DATA: begin
            if (r_bit_cnt != LAST_BIT) begin
              r_line    <= r_shift[1];
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end else if (r_par_en) begin
              r_line  <= r_par;
              r_state <= S_PARITY;
            end else begin
              r_line     <= 1'b1;
              r_stop_cnt <= 1'b0;
              r_state    <= S_STOP;
            end
          end
          S_PARITY: begin
            r_line     <= 1'b1;
            r_stop_cnt <= 1'b0;
            r_state    <= S_STOP;
          end
          S_STOP: begin
            if (r_two_stop && !r_stop_cnt) begin
              r_stop_cnt <= 1'b1;
            end else begin
              r_done  <= 1'b1;
              r_ena   <= 1'b0;
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (w_wd_expired) begin
        r_line  <= 1'b1;
        r_ena   <= 1'b0;
        r_busy  <= 1'b0;
        r_ready <= 1'b1;
        r_err   <= 1'b1;
        r_state <= S_IDLE;
      end else begin
        r_wd <= r_wd + 20'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: table-driven frames, random frames
// against a bit-list reference model, back-to-back, watchdog and reset cases.
module tb_uart_tx_ctrl;
  localparam int unsigned DB = 8;
  localparam int unsigned TT = 60;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.DATA_BITS(DB)) bus ();

  uart_tx_ctrl #(
    .DATA_BITS(DB),
    .DEFAULT_BAUD(3'b011),
    .TICK_TIMEOUT(TT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  data;
    logic        par_en;
    logic        par_odd;
    logic        two_stop;
    logic [2:0]  cfg_baud;
    logic [2:0]  exp_baud;
    logic        exp_par;
    int unsigned exp_ticks;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic tick);
    bus.baud_tick = tick;
    @(posedge clk);
    #1;
    bus.baud_tick = 1'b0;
  endtask

  // Sends one frame and checks every cycle against a bit list built from the
  // frame rules. hold keeps tx_valid high with next_data for a back-to-back send.
  task automatic run_frame(input logic [7:0] data, input logic par_en, input logic par_odd,
                           input logic two_stop, input logic [2:0] cfg_baud,
                           input int unsigned period, input logic hold,
                           input logic [7:0] next_data,
                           output logic obs_par, output int unsigned n_ticks,
                           output logic [2:0] got_baud);
    logic        bits[$];
    logic [2:0]  exp_b;
    int unsigned f, ticks, cyc, phase, bad_line, bad_ctl;
    logic        finished, tick, exp_line;
    bits.delete();
    bits.push_back(1'b0);
    for (int i = 0; i < int'(DB); i++) bits.push_back(data[i]);
    if (par_en) bits.push_back((($countones(data) % 2) == 1) ^ par_odd);
    bits.push_back(1'b1);
    if (two_stop) bits.push_back(1'b1);
    f = bits.size();
    exp_b = (cfg_baud >= 3'd6) ? 3'd3 : cfg_baud;
    obs_par = 1'bx;

    bus.tx_valid       = 1'b1;
    bus.tx_data        = data;
    bus.cfg_parity_en  = par_en;
    bus.cfg_parity_odd = par_odd;
    bus.cfg_two_stop   = two_stop;
    bus.cfg_baud_set   = cfg_baud;
    step(1'b0);
    chk("accept_flags", {bus.tx_ready, bus.tx_busy, bus.baud_ena, bus.tx_done, bus.tx_line},
        5'b01101);
    got_baud = bus.baud_set;
    chk("accept_baud", bus.baud_set, exp_b);
    if (hold) bus.tx_data = next_data;
    else bus.tx_valid = 1'b0;

    ticks = 0; cyc = 0; bad_line = 0; bad_ctl = 0; finished = 1'b0;
    phase = $urandom_range(period - 1, 0);
    while (!finished && cyc < (f + 3) * period + 10) begin
      tick = ((cyc % period) == phase);
      cyc++;
      if (!hold) begin
        bus.tx_valid       = 1'($urandom);
        bus.tx_data        = 8'($urandom);
        bus.cfg_baud_set   = 3'($urandom);
        bus.cfg_parity_en  = 1'($urandom);
        bus.cfg_parity_odd = 1'($urandom);
        bus.cfg_two_stop   = 1'($urandom);
      end
      step(tick);
      if (tick) ticks++;
      if (ticks <= f) begin
        exp_line = (ticks == 0) ? 1'b1 : bits[ticks-1];
        if (bus.tx_line !== exp_line) bad_line++;
        if (par_en && tick && ticks == DB + 2) obs_par = bus.tx_line;
        if ({bus.tx_busy, bus.baud_ena, bus.tx_ready, bus.tx_done, bus.tx_err} !== 5'b11000 ||
            bus.baud_set !== exp_b) bad_ctl++;
      end else begin
        finished = 1'b1;
        chk("frame_end_flags",
            {bus.tx_done, bus.tx_ready, bus.tx_busy, bus.baud_ena, bus.tx_err, bus.tx_line},
            6'b110001);
      end
    end
    if (!hold) bus.tx_valid = 1'b0;
    chk("frame_finished", finished, 1'b1);
    chk("line_bits", bad_line, 0);
    chk("ctl_in_frame", bad_ctl, 0);
    n_ticks = ticks;
    if (!hold) begin
      step(1'b0);
      chk("done_one_cycle", {bus.tx_done, bus.tx_line, bus.tx_ready, bus.tx_busy}, 4'b0110);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic        op;
    int unsigned nt, bad, n;
    logic [2:0]  gb;
    logic        got;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 3'b011, 3'b011, 1'b0, 11};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b1, 3'b011, 3'b011, 1'b0, 13};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b1, 3'b011, 3'b011, 1'b1, 13};
    vecs[3] = '{8'h5A, 1'b0, 1'b0, 1'b0, 3'b101, 3'b101, 1'b0, 11};
    vecs[4] = '{8'h3C, 1'b1, 1'b0, 1'b0, 3'b111, 3'b011, 1'b0, 12};
    vecs[5] = '{8'h01, 1'b1, 1'b1, 1'b0, 3'b110, 3'b011, 1'b0, 12};
    vecs[6] = '{8'h80, 1'b1, 1'b0, 1'b1, 3'b000, 3'b000, 1'b1, 13};
    vecs[7] = '{8'h00, 1'b0, 1'b0, 1'b1, 3'b100, 3'b100, 1'b0, 12};

    bus.tx_valid = 1'b0; bus.tx_data = '0; bus.cfg_baud_set = '0;
    bus.cfg_parity_en = 1'b0; bus.cfg_parity_odd = 1'b0; bus.cfg_two_stop = 1'b0;
    bus.baud_tick = 1'b0;

    reset_n = 1'b0;
    repeat (3) step(1'b0);
    reset_n = 1'b1;
    step(1'b0);
    chk("reset_state", {bus.tx_line, bus.tx_ready, bus.tx_busy, bus.baud_ena,
                        bus.tx_done, bus.tx_err, bus.baud_set}, 9'b110000011);

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step(i % 2 == 0);
      if ({bus.tx_line, bus.tx_ready, bus.tx_busy, bus.baud_ena, bus.tx_done, bus.tx_err,
           bus.baud_set} !== 9'b110000011) bad++;
    end
    chk("idle_ticks_ignored", bad, 0);

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i].data, vecs[i].par_en, vecs[i].par_odd, vecs[i].two_stop,
                vecs[i].cfg_baud, 10, 1'b0, 8'h00, op, nt, gb);
      chk("vec_baud", gb, vecs[i].exp_baud);
      chk("vec_ticks", nt, vecs[i].exp_ticks);
      if (vecs[i].par_en) chk("vec_parity", op, vecs[i].exp_par);
    end

    for (int i = 0; i < 20; i++) begin
      run_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
                $urandom_range(20, 2), 1'b0, 8'h00, op, nt, gb);
    end

    run_frame(8'h00, 1'b0, 1'b0, 1'b0, 3'b011, 10, 1'b1, 8'hFF, op, nt, gb);
    run_frame(8'hFF, 1'b0, 1'b0, 1'b0, 3'b011, 10, 1'b0, 8'h00, op, nt, gb);
    chk("b2b_second_ticks", nt, 11);

    bus.tx_valid = 1'b1; bus.tx_data = 8'hC3; bus.cfg_baud_set = 3'b010;
    bus.cfg_parity_en = 1'b0; bus.cfg_two_stop = 1'b0;
    step(1'b0);
    bus.tx_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      repeat (9) step(1'b0);
      step(1'b1);
    end
    n = 0; got = 1'b0;
    while (!got && n < 2 * TT) begin
      step(1'b0);
      n++;
      if (bus.tx_err) got = 1'b1;
    end
    chk("wd_latency", n, TT);
    chk("wd_state", {bus.tx_err, bus.tx_line, bus.tx_ready, bus.tx_busy, bus.baud_ena,
                     bus.tx_done}, 6'b111000);
    step(1'b0);
    chk("wd_err_pulse", {bus.tx_err, bus.tx_done}, 2'b00);

    bus.tx_valid = 1'b1; bus.tx_data = 8'h0F; bus.cfg_baud_set = 3'b101;
    step(1'b0);
    bus.tx_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      repeat (4) step(1'b0);
      step(1'b1);
    end
    reset_n = 1'b0;
    step(1'b0);
    chk("reset_mid_frame", {bus.tx_line, bus.tx_ready, bus.tx_busy, bus.baud_ena,
                            bus.tx_done, bus.tx_err, bus.baud_set}, 9'b110000011);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step(i % 3 == 0);
      if ({bus.tx_line, bus.tx_ready, bus.tx_busy, bus.tx_done, bus.tx_err} !== 5'b11000) bad++;
    end
    chk("after_reset_quiet", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
